// File: rtl/hs_word_packer.sv
// hs_word_packer
//   Packs 32-bit event words into 128-bit beats for the HS data channel of the
//   Ethernet transmit controller. Four accepted words form one beat. The
//   oldest word goes in bits [127:96]. If a group stays partial for
//   TIMEOUT_CYCLES idle cycles, it is padded with PAD_WORD and flushed. A small
//   output FIFO absorbs downstream back-pressure.
//
// Parameters
//   FIFO_DEPTH     : output FIFO depth in 128-bit entries (power of two, >= 2)
//   TIMEOUT_CYCLES : idle cycles before a partial group is flushed (>= 2)
//   PAD_WORD       : filler for unused 32-bit slots on a flush
//
// Ports
//   clk           in    : clock, all logic on the rising edge
//   rst           in    : synchronous active-high reset
//   in_data       in 32 : event word
//   in_valid      in    : in_data valid
//   in_ready      out   : word is accepted this cycle when in_valid is high
//   hs_data       out128: FIFO head
//   hs_data_valid out   : FIFO not empty
//   hs_data_ready in    : downstream consumes the head this cycle
//
// Optional build macro HS_PACKER_STATS_EN adds the following outputs:
//   packed_count  out 32: number of FIFO pushes (wraps)
//   pad_count     out 32: number of flush (padded) pushes (wraps)
module hs_word_packer #(
  parameter int          FIFO_DEPTH     = 4,
  parameter int          TIMEOUT_CYCLES = 1024,
  parameter logic [31:0] PAD_WORD       = 32'hFFFF_FFFF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [31:0]  in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [127:0] hs_data,
  output logic         hs_data_valid,
  input  logic         hs_data_ready
`ifdef HS_PACKER_STATS_EN
  ,
  output logic [31:0]  packed_count,
  output logic [31:0]  pad_count
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [AW:0]   FIFO_FULL_COUNT = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_EMPTY      = 2'd0,
    S_FILLING    = 2'd1,
    S_FLUSH_WAIT = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [1:0]      fill_q;
  logic [95:0]     asm_q;          // slot0 [95:64], slot1 [63:32], slot2 [31:0]
  logic [CW-1:0]   cnt_q;
  logic [127:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [AW:0]     count_q;

  logic            fifo_full;
  logic            timeout;
  logic            accept;
  logic            push_full;
  logic            flush;
  logic            push;
  logic            pop;
  logic [127:0]    flush_word;
  logic [127:0]    push_data;

  assign fifo_full = (count_q == FIFO_FULL_COUNT);
  assign timeout   = (cnt_q == CNT_MAX);

  // Padded beat: slots below fill_q carry assembled words, the rest are filler.
  // Slot 3 is never occupied at flush time.
  for (genvar gi = 0; gi < 4; gi++) begin : g_flush_slot
    if (gi < 3) begin : g_data
      assign flush_word[127-32*gi -: 32] =
        (fill_q > 2'(gi)) ? asm_q[95-32*gi -: 32] : PAD_WORD;
    end else begin : g_pad
      assign flush_word[127-32*gi -: 32] = PAD_WORD;
    end
  end

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_EMPTY;
    else     state_q <= state_d;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_EMPTY: begin
        if (accept) state_d = S_FILLING;
      end
      S_FILLING: begin
        if (push_full || flush)                state_d = S_EMPTY;
        else if (!accept && timeout && fifo_full) state_d = S_FLUSH_WAIT;
      end
      S_FLUSH_WAIT: begin
        if (flush) state_d = S_EMPTY;
      end
      default: state_d = S_EMPTY;
    endcase
  end

  // ---------------- FSM: outputs / control ----------------
  // in_ready is derived from registered state only, with no path from
  // hs_data_ready. A pop cannot make room for a push on the same edge.
  always_comb begin
    in_ready  = ~rst & (state_q != S_FLUSH_WAIT) & ~((fill_q == 2'd3) & fifo_full);
    accept    = in_valid & in_ready;
    push_full = accept & (fill_q == 2'd3);
    // An accept coinciding with the timeout takes priority over the flush.
    flush     = ~accept & ~fifo_full &
                (((state_q == S_FILLING) & timeout) | (state_q == S_FLUSH_WAIT));
    push      = push_full | flush;
    push_data = push_full ? {asm_q, in_data} : flush_word;
  end

  assign hs_data_valid = ~rst & (count_q != '0);
  assign hs_data       = rst ? '0 : mem_q[rd_ptr_q];
  assign pop           = hs_data_valid & hs_data_ready;

  // ---------------- Assembly register, fill and idle counter ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      asm_q  <= '0;
      fill_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (accept) begin
        case (fill_q)
          2'd0:    asm_q[95:64] <= in_data;
          2'd1:    asm_q[63:32] <= in_data;
          2'd2:    asm_q[31:0]  <= in_data;
          default: ;  // the fourth word goes straight into the FIFO
        endcase
      end

      if (push)        fill_q <= '0;
      else if (accept) fill_q <= fill_q + 2'd1;

      if (accept || flush)
        cnt_q <= '0;
      else if (state_q == S_FILLING && !timeout)
        cnt_q <= cnt_q + CW'(1);
    end
  end

  // ---------------- Output FIFO ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= push_data;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + (AW+1)'(push) - (AW+1)'(pop);
    end
  end

`ifdef HS_PACKER_STATS_EN
  logic [31:0] packed_count_q, pad_count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      packed_count_q <= '0;
      pad_count_q    <= '0;
    end else begin
      if (push)  packed_count_q <= packed_count_q + 32'd1;
      if (flush) pad_count_q    <= pad_count_q + 32'd1;
    end
  end

  assign packed_count = packed_count_q;
  assign pad_count    = pad_count_q;
`endif

endmodule
